ctrl_seq_v2: RTL
================

Name: ctrl_seq_v2

Overview:
Parametrised second-generation control sequencer for the lab datapath (register file X/Y ports, A/G registers, add/sub unit, immediate path, display latch, PC and instruction latch).
It extends the original sequencer with:
- a 4-bit opcode space
- a request/acknowledge instruction-fetch handshake with timeout
- a branch-if-zero instruction
- illegal-opcode fault trapping
- resumable HALT
- a retired-instruction counter

All datapath control outputs are decoded from the current state, with the Mealy exceptions noted below.

Parameters:
OP_W, 4, opcode input width; must be >=4; any nonzero bit above bit 3 makes the opcode illegal
FETCH_TMO, 15, cycles FETCH may wait for imem_ack before FAULT (1..255)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
opcode  in  OP_W  opcode field from instruction latch, valid from DECODE onward
imem_ack  in  1  instruction memory ready; instruction word valid this cycle
g_zero  in  1  G register equals zero
run  in  1  single-cycle pulse that resumes from HALT
imem_req  out  1  instruction fetch request
_Extern, Gout, Iout, Ain, Gin, DPin, RdX, RdY, WrX, add_sub  out  1 each  datapath controls, same meanings as the first-generation sequencer
pc_en  out  1  PC increment enable
ILin  out  1  instruction latch enable
br_en  out  1  load PC from immediate (branch taken)
halted  out  1  state is HALT
fault  out  1  state is FAULT (sticky)
retired  out  CNT_W  count of completed instructions, wraps
cur_state  out  4  state encoding

Behaviour:
State encodings (4 bits):
- FETCH=0, LOAD=1, READ_Y=2, READ_X=3, ADD=4, SUB=5, MV=6, WRITE_X=7
- BRZ=8, ADDI=9, SUBI=10, DISP=11, DECODE=12, NOP=13, HALT=14, FAULT=15

Opcodes:
- 0000 LOAD, 0001 MV, 0010 SUB, 0011 ADD
- 0100 DISP, 0101 HALT, 0110 SUBI, 0111 ADDI
- 1000 BRZ, 1001 NOP
- 1010–1111 and any upper-bit-set value are illegal

Reset:
- state=FETCH, op_q=0, timer=0, retired=0
- While reset is high, every output is 0 except cur_state=0.

Output decode (all unlisted outputs 0):
- FETCH: imem_req=1; pc_en=ILin=imem_ack (Mealy)
- LOAD: _Extern, WrX
- READ_Y: Ain, RdY
- READ_X: Ain, RdX
- ADD: Gin, RdX
- SUB: Gin, RdY, add_sub
- MV: Gin
- ADDI: Iout, Gin
- SUBI: Iout, Gin, add_sub
- WRITE_X: Gout, WrX
- DISP: DPin, RdX
- BRZ: br_en=g_zero (Mealy)
- HALT: halted
- FAULT: fault
- DECODE, NOP: none

Opcode capture:
- DECODE registers opcode into op_q.
- All later branching uses op_q, never the live input.

Transitions:
- FETCH: on imem_ack go to DECODE and clear the timer. Otherwise increment the timer; when the timer equals FETCH_TMO-1 with no ack, go to FAULT.
- DECODE: 0000->LOAD; 0001,0011->READ_Y; 0010,0110,0111->READ_X; 0100->DISP; 0101->HALT; 1000->BRZ; 1001->NOP; illegal->FAULT.
- READ_Y: op_q MV->MV, ADD->ADD.
- READ_X: SUB->SUB, SUBI->SUBI, ADDI->ADDI.
- ADD, SUB, MV, ADDI, SUBI: go to WRITE_X.
- LOAD, WRITE_X, DISP, BRZ, NOP: go to FETCH.
- HALT: stays until run=1, then FETCH.
- FAULT: terminal until reset; run is ignored.
- Any unreachable state goes to FAULT.

Latency per instruction (cycles after the fetch-ack cycle):
- LOAD, DISP, BRZ, NOP: DECODE + 1
- MV, ADD, SUB, ADDI, SUBI: DECODE + 3

Retired counter:
- Increments by 1 on every transition into FETCH from LOAD, WRITE_X, DISP, BRZ or NOP.
- Increments by 1 on entering HALT.
- Wraps from 2^CNT_W-1 to 0.
- Does not count FAULT.

Boundary and corner cases:
- imem_ack outside FETCH is ignored.
- run outside HALT is ignored.
- run and imem_ack together while in HALT: leave to FETCH only; imem_ack is ignored that cycle.
- Reset asserted mid-instruction: abort immediately; no WrX or Gin pulse completes.

Decomposition:
- Package ctrl_seq_pkg holds the opcode constants, state constants and the illegal-opcode predicate.
- One sub-module, ctrl_fetch_timer, implements the saturating wait counter. Inputs: clk, reset, clear, inc. Output: expired.

Test Plan:
- Reset, then imem_ack held 1 with opcode 0011:
  - states go FETCH, DECODE, READ_Y, ADD, WRITE_X, FETCH
  - WRITE_X cycle shows Gout=1 and WrX=1
  - retired=1
- Opcode 1000 with g_zero=1, then 1000 with g_zero=0: br_en pulses exactly one cycle in BRZ for the first only; retired=2.
- imem_ack held 0 with FETCH_TMO=15: after 15 cycles in FETCH, state=15 and fault=1; run and imem_ack are then ignored until reset.
- Opcode 1100:
  - DECODE goes to FAULT
  - opcode changing to 0000 afterwards has no effect
- Opcode 0101: halted=1; state holds for 20 cycles; a run pulse gives FETCH next cycle; retired incremented once.
- Reset pulsed during SUB: outputs 0 while reset is high; state=FETCH and retired=0 after release; preset CNT_W=4 with 16 NOPs gives retired wrapping to 0.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// Shared encodings for the second-generation control sequencer:
// state codes, opcode values and the illegal-opcode predicate.
package ctrl_seq_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_LOAD  = 4'd1,  S_READ_Y = 4'd2,  S_READ_X = 4'd3,
    S_ADD    = 4'd4,  S_SUB   = 4'd5,  S_MV     = 4'd6,  S_WRITE_X = 4'd7,
    S_BRZ    = 4'd8,  S_ADDI  = 4'd9,  S_SUBI   = 4'd10, S_DISP   = 4'd11,
    S_DECODE = 4'd12, S_NOP   = 4'd13, S_HALT   = 4'd14, S_FAULT  = 4'd15
  } state_t;

  localparam logic [3:0] OP_LOAD = 4'h0;
  localparam logic [3:0] OP_MV   = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_DISP = 4'h4;
  localparam logic [3:0] OP_HALT = 4'h5;
  localparam logic [3:0] OP_SUBI = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_BRZ  = 4'h8;
  localparam logic [3:0] OP_NOP  = 4'h9;

  // Opcode arrives zero-extended, so any upper bit set also lands above 9.
  function automatic logic op_illegal(input logic [31:0] op);
    return op > 32'd9;
  endfunction

endpackage

// File: rtl/ctrl_fetch_timer.sv
// Saturating wait counter for the FETCH handshake; expired flags the
// last permitted wait cycle.
module ctrl_fetch_timer #(
  parameter int TMO = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         r_cnt <= '0;
    else if (clear)                    r_cnt <= '0;
    else if (inc && r_cnt != 8'hFF)    r_cnt <= r_cnt + 8'd1;
  end

  assign expired = (r_cnt == 8'(TMO - 1));

endmodule

// File: rtl/ctrl_seq_v2.sv
// Second-generation lab datapath sequencer: fetch handshake with timeout,
// branch-if-zero, fault trap, resumable halt and retired-instruction count.
module ctrl_seq_v2
  import ctrl_seq_pkg::*;
#(
  parameter int OP_W      = 4,
  parameter int FETCH_TMO = 15,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  opcode,
  input  logic             imem_ack,
  input  logic             g_zero,
  input  logic             run,
  output logic             imem_req,
  output logic             _Extern,
  output logic             Gout,
  output logic             Iout,
  output logic             Ain,
  output logic             Gin,
  output logic             DPin,
  output logic             RdX,
  output logic             RdY,
  output logic             WrX,
  output logic             add_sub,
  output logic             pc_en,
  output logic             ILin,
  output logic             br_en,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       cur_state
);

  state_t            r_state, w_next;
  logic [3:0]        r_op_q;
  logic [CNT_W-1:0]  r_retired;
  logic              w_ret_inc, w_expired, w_illegal, w_in_fetch;

  assign w_illegal  = op_illegal(32'(opcode));
  assign w_in_fetch = (r_state == S_FETCH);

  ctrl_fetch_timer #(.TMO(FETCH_TMO)) u_tmr (
    .clk     (clk),
    .reset   (reset),
    .clear   (!w_in_fetch || imem_ack),
    .inc     (w_in_fetch && !imem_ack),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_op_q    <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op_q <= opcode[3:0];
      if (w_ret_inc)           r_retired <= r_retired + 1'b1;
    end
  end

  always_comb begin
    w_next    = S_FAULT;
    w_ret_inc = 1'b0;
    case (r_state)
      S_FETCH:  w_next = imem_ack ? S_DECODE : (w_expired ? S_FAULT : S_FETCH);
      S_DECODE: begin
        if (!w_illegal) begin
          case (opcode[3:0])
            OP_LOAD:                  w_next = S_LOAD;
            OP_MV, OP_ADD:            w_next = S_READ_Y;
            OP_SUB, OP_SUBI, OP_ADDI: w_next = S_READ_X;
            OP_DISP:                  w_next = S_DISP;
            OP_HALT: begin
              w_next    = S_HALT;
              w_ret_inc = 1'b1;
            end
            OP_BRZ:                   w_next = S_BRZ;
            OP_NOP:                   w_next = S_NOP;
            default:                  w_next = S_FAULT;
          endcase
        end
      end
      S_READ_Y: begin
        if (r_op_q == OP_MV)       w_next = S_MV;
        else if (r_op_q == OP_ADD) w_next = S_ADD;
      end
      S_READ_X: begin
        if (r_op_q == OP_SUB)       w_next = S_SUB;
        else if (r_op_q == OP_SUBI) w_next = S_SUBI;
        else if (r_op_q == OP_ADDI) w_next = S_ADDI;
      end
      S_ADD, S_SUB, S_MV, S_ADDI, S_SUBI: w_next = S_WRITE_X;
      S_LOAD, S_WRITE_X, S_DISP, S_BRZ, S_NOP: begin
        w_next    = S_FETCH;
        w_ret_inc = 1'b1;
      end
      S_HALT:  w_next = run ? S_FETCH : S_HALT;
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_FAULT;
    endcase
  end

  // Gating on reset keeps the Mealy FETCH/BRZ terms quiet while reset is held.
  always_comb begin
    imem_req = 1'b0; _Extern = 1'b0; Gout = 1'b0; Iout = 1'b0;
    Ain = 1'b0; Gin = 1'b0; DPin = 1'b0; RdX = 1'b0; RdY = 1'b0;
    WrX = 1'b0; add_sub = 1'b0; pc_en = 1'b0; ILin = 1'b0;
    br_en = 1'b0; halted = 1'b0; fault = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          imem_req = 1'b1;
          pc_en    = imem_ack;
          ILin     = imem_ack;
        end
        S_LOAD:    begin _Extern = 1'b1; WrX = 1'b1; end
        S_READ_Y:  begin Ain = 1'b1; RdY = 1'b1; end
        S_READ_X:  begin Ain = 1'b1; RdX = 1'b1; end
        S_ADD:     begin Gin = 1'b1; RdX = 1'b1; end
        S_SUB:     begin Gin = 1'b1; RdY = 1'b1; add_sub = 1'b1; end
        S_MV:      Gin = 1'b1;
        S_ADDI:    begin Iout = 1'b1; Gin = 1'b1; end
        S_SUBI:    begin Iout = 1'b1; Gin = 1'b1; add_sub = 1'b1; end
        S_WRITE_X: begin Gout = 1'b1; WrX = 1'b1; end
        S_DISP:    begin DPin = 1'b1; RdX = 1'b1; end
        S_BRZ:     br_en = g_zero;
        S_HALT:    halted = 1'b1;
        S_FAULT:   fault = 1'b1;
        default:   ;
      endcase
    end
  end

  assign retired   = r_retired;
  assign cur_state = r_state;

endmodule
